// File: rtl/ucode_pkg.sv
// Shared types, opcodes and instruction encoders for the microcode multiply sequencer.
package ucode_pkg;

  typedef enum logic [1:0] {
    MUL_I  = 2'd0,
    MUL_R  = 2'd1,
    MUL_SI = 2'd2,
    MUL_SR = 2'd3
  } mul_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIAS_CLR,
    ST_ALIAS_CP,
    ST_CLR,
    ST_ADD,
    ST_FIX1,
    ST_FIX2,
    ST_DONE
  } state_e;

  localparam logic [6:0]  OP_MOV     = 7'b0000000;
  localparam logic [6:0]  OP_ADD     = 7'b0110001;
  localparam logic [6:0]  OP_ADDS    = 7'b0111001;
  localparam logic [6:0]  OP_SUBI    = 7'b0010010;
  localparam logic [6:0]  OP_NOT     = 7'b0110110;
  localparam logic [4:0]  NOP_PREFIX = 5'b11001;
  localparam logic [31:0] INSTR_NOP  = {NOP_PREFIX, 27'b0};

  function automatic logic [31:0] enc_r(input logic [6:0] op, input logic [3:0] rd,
                                        input logic [3:0] rn, input logic [3:0] rm);
    return {op, rd, rn, rm, 13'b0};
  endfunction

  function automatic logic [31:0] enc_mov(input logic [3:0] rd, input logic [15:0] imm);
    return {OP_MOV, rd, 5'b0, imm};
  endfunction

  function automatic logic [31:0] enc_subi(input logic [3:0] rd, input logic [3:0] rn,
                                           input logic [15:0] imm);
    return {OP_SUBI, rd, rn, 1'b0, imm};
  endfunction

  function automatic logic [31:0] enc_not(input logic [3:0] rd, input logic [3:0] rn);
    return {OP_NOT, rd, rn, 17'b0};
  endfunction

  function automatic logic is_reg_form(input logic [1:0] t);
    return (mul_type_e'(t) == MUL_R) || (mul_type_e'(t) == MUL_SR);
  endfunction

  function automatic logic is_s_type(input logic [1:0] t);
    return (mul_type_e'(t) == MUL_SI) || (mul_type_e'(t) == MUL_SR);
  endfunction

endpackage

// File: rtl/ucode_operand_sel.sv
// Picks the multiplier and addend register for a MUL request and derives the
// repeat count (magnitude) and sign of the multiplier.
module ucode_operand_sel
  import ucode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic [1:0]        mul_type,
  input  logic [3:0]        src_reg,
  input  logic [3:0]        src2_reg,
  input  logic [IMM_W-1:0]  immediate,
  input  logic [DATA_W-1:0] rn_data,
  input  logic [DATA_W-1:0] rm_data,
  output logic [DATA_W-1:0] count,
  output logic              neg,
  output logic [3:0]        a_reg
);

  // The most negative value maps onto itself, which is exactly 2^(DATA_W-1) unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? -v : v;
  endfunction

  logic [DATA_W-1:0] mag_rn;
  logic [DATA_W-1:0] mag_rm;
  logic [DATA_W-1:0] m_val;

  always_comb begin
    mag_rn = magnitude(rn_data);
    mag_rm = magnitude(rm_data);
    m_val  = DATA_W'($signed(immediate));
    a_reg  = src_reg;
    // Fewer adds when the smaller operand drives the loop; ties favour Rm.
    if (is_reg_form(mul_type)) begin
      if (mag_rn < mag_rm) begin
        m_val = rn_data;
        a_reg = src2_reg;
      end else begin
        m_val = rm_data;
        a_reg = src_reg;
      end
    end
    count = magnitude(m_val);
    neg   = m_val[DATA_W-1];
  end

endmodule

// File: rtl/ucode_mul_seq.sv
// Microcode multiply sequencer: expands MUL/MULS into MOV/ADD(S)/SUBI/NOT
// injections with a valid/ready stall handshake and flush abort.
module ucode_mul_seq
  import ucode_pkg::*;
#(
  parameter int         DATA_W      = 32,
  parameter int         IMM_W       = 16,
  parameter logic [3:0] SCRATCH_REG = 4'd15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_mul,
  output logic              start_ready,
  input  logic [1:0]        mul_type,
  input  logic [3:0]        dest_reg,
  input  logic [3:0]        src_reg,
  input  logic [3:0]        src2_reg,
  input  logic [IMM_W-1:0]  immediate,
  input  logic [DATA_W-1:0] rn_data,
  input  logic [DATA_W-1:0] rm_data,
  input  logic [3:0]        flags_in,
  output logic [31:0]       inject_instr,
  output logic              inject_valid,
  input  logic              inject_ready,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic              flags_restore,
  output logic [3:0]        flags_out
);

  state_e            state;
  state_e            state_next;
  logic [DATA_W-1:0] count_q;
  logic              neg_q;
  logic [3:0]        rd_q;
  logic [3:0]        a_q;
  logic              s_type_q;
  logic [3:0]        saved_flags_q;

  logic [DATA_W-1:0] sel_count;
  logic              sel_neg;
  logic [3:0]        sel_a;
  logic              alias_hit;
  logic              accept;
  logic              fire;
  logic [6:0]        add_op;

  ucode_operand_sel #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_operand_sel (
    .mul_type  (mul_type),
    .src_reg   (src_reg),
    .src2_reg  (src2_reg),
    .immediate (immediate),
    .rn_data   (rn_data),
    .rm_data   (rm_data),
    .count     (sel_count),
    .neg       (sel_neg),
    .a_reg     (sel_a)
  );

  assign alias_hit = (sel_a == dest_reg) && (sel_count != '0);
  assign accept    = (state == ST_IDLE) && start_mul && !flush;
  assign fire      = inject_valid && inject_ready;
  assign add_op    = s_type_q ? OP_ADDS : OP_ADD;

  always_comb begin
    state_next = state;
    if (state != ST_IDLE && flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      if (accept) state_next = alias_hit ? ST_ALIAS_CLR : ST_CLR;
        ST_ALIAS_CLR: if (fire) state_next = ST_ALIAS_CP;
        ST_ALIAS_CP:  if (fire) state_next = ST_CLR;
        ST_CLR:       if (fire) state_next = (count_q == '0) ? ST_DONE : ST_ADD;
        ST_ADD:       if (fire && count_q == DATA_W'(1)) state_next = neg_q ? ST_FIX1 : ST_DONE;
        ST_FIX1:      if (fire) state_next = ST_FIX2;
        ST_FIX2:      if (fire) state_next = ST_DONE;
        ST_DONE:      state_next = ST_IDLE;
        default:      state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    inject_valid = 1'b0;
    inject_instr = INSTR_NOP;
    case (state)
      ST_ALIAS_CLR: begin
        inject_valid = 1'b1;
        inject_instr = enc_mov(SCRATCH_REG, 16'd0);
      end
      ST_ALIAS_CP: begin
        inject_valid = 1'b1;
        inject_instr = enc_r(OP_ADD, SCRATCH_REG, SCRATCH_REG, a_q);
      end
      ST_CLR: begin
        inject_valid = 1'b1;
        inject_instr = enc_mov(rd_q, 16'd0);
      end
      ST_ADD: begin
        inject_valid = 1'b1;
        inject_instr = enc_r(add_op, rd_q, rd_q, a_q);
      end
      ST_FIX1: begin
        inject_valid = 1'b1;
        inject_instr = enc_subi(rd_q, rd_q, 16'd1);
      end
      ST_FIX2: begin
        inject_valid = 1'b1;
        inject_instr = enc_not(rd_q, rd_q);
      end
      default: begin
        inject_valid = 1'b0;
        inject_instr = INSTR_NOP;
      end
    endcase
  end

  assign start_ready   = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);
  assign flags_restore = done && !s_type_q;
  assign flags_out     = flags_restore ? saved_flags_q : 4'b0;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Once the alias copy is made, every later add reads the scratch register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q       <= '0;
      neg_q         <= 1'b0;
      rd_q          <= 4'd0;
      a_q           <= 4'd0;
      s_type_q      <= 1'b0;
      saved_flags_q <= 4'd0;
    end else if (accept) begin
      count_q       <= sel_count;
      neg_q         <= sel_neg;
      rd_q          <= dest_reg;
      a_q           <= sel_a;
      s_type_q      <= is_s_type(mul_type);
      saved_flags_q <= flags_in;
    end else if (fire && !flush) begin
      if (state == ST_ALIAS_CP) a_q <= SCRATCH_REG;
      if (state == ST_ADD) count_q <= count_q - DATA_W'(1);
    end
  end

endmodule

// File: tb/tb_ucode_mul_seq.sv
// Directed self-checking bench for ucode_mul_seq with hand-derived instruction streams.
module tb_ucode_mul_seq;

  localparam logic [6:0]  B_MOV  = 7'b0000000;
  localparam logic [6:0]  B_ADD  = 7'b0110001;
  localparam logic [6:0]  B_ADDS = 7'b0111001;
  localparam logic [6:0]  B_SUBI = 7'b0010010;
  localparam logic [6:0]  B_NOT  = 7'b0110110;
  localparam logic [31:0] B_NOP  = 32'hC800_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_mul = 1'b0;
  logic        start_ready;
  logic [1:0]  mul_type = 2'd0;
  logic [3:0]  dest_reg = 4'd0, src_reg = 4'd0, src2_reg = 4'd0;
  logic [15:0] immediate = 16'd0;
  logic [31:0] rn_data = 32'd0, rm_data = 32'd0;
  logic [3:0]  flags_in = 4'd0;
  logic [31:0] inject_instr;
  logic        inject_valid;
  logic        inject_ready = 1'b1;
  logic        flush = 1'b0;
  logic        busy, done, flags_restore;
  logic [3:0]  flags_out;

  int checks = 0;
  int failures = 0;

  logic [31:0] got[$];
  logic [31:0] exp[$];
  logic        done_seen, restore_seen, timed_out;
  logic [3:0]  flags_seen;
  int          busy_cycles;

  always #5 clk = ~clk;

  ucode_mul_seq dut (
    .clk           (clk),
    .rst           (rst),
    .start_mul     (start_mul),
    .start_ready   (start_ready),
    .mul_type      (mul_type),
    .dest_reg      (dest_reg),
    .src_reg       (src_reg),
    .src2_reg      (src2_reg),
    .immediate     (immediate),
    .rn_data       (rn_data),
    .rm_data       (rm_data),
    .flags_in      (flags_in),
    .inject_instr  (inject_instr),
    .inject_valid  (inject_valid),
    .inject_ready  (inject_ready),
    .flush         (flush),
    .busy          (busy),
    .done          (done),
    .flags_restore (flags_restore),
    .flags_out     (flags_out)
  );

  function automatic logic [31:0] e_r(input logic [6:0] op, input logic [3:0] rd,
                                      input logic [3:0] rn, input logic [3:0] rm);
    return {op, rd, rn, rm, 13'b0};
  endfunction
  function automatic logic [31:0] e_mov(input logic [3:0] rd);
    return {B_MOV, rd, 5'b0, 16'd0};
  endfunction
  function automatic logic [31:0] e_subi1(input logic [3:0] rd);
    return {B_SUBI, rd, rd, 1'b0, 16'd1};
  endfunction
  function automatic logic [31:0] e_not(input logic [3:0] rd);
    return {B_NOT, rd, rd, 17'b0};
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 one cycle after accept.
  task automatic issue(input logic [1:0] t, input logic [3:0] rd, input logic [3:0] rn,
                       input logic [3:0] rm, input logic [15:0] imm, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] f);
    start_mul = 1'b1; mul_type = t; dest_reg = rd; src_reg = rn; src2_reg = rm;
    immediate = imm; rn_data = a; rm_data = b; flags_in = f;
    @(posedge clk); #1;
    start_mul = 1'b0; rn_data = 32'hDEAD_BEEF; rm_data = 32'h0BAD_F00D; flags_in = 4'd0;
  endtask

  // Records accepted instructions until done or the cycle budget runs out.
  task automatic capture(input int budget);
    got.delete();
    done_seen = 1'b0; restore_seen = 1'b0; flags_seen = 4'd0; busy_cycles = 0; timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (busy) busy_cycles++;
      if (inject_valid && inject_ready) got.push_back(inject_instr);
      if (done) begin
        done_seen = 1'b1; restore_seen = flags_restore; flags_seen = flags_out; timed_out = 1'b0;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (inject_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", inject_valid); end
    checks++; if (inject_instr !== B_NOP) begin failures++; $display("[TB] FAIL reset_instr got=%h exp=%h", inject_instr, B_NOP); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    checks++; if ({flags_restore, flags_out} !== 5'b0) begin failures++; $display("[TB] FAIL reset_flags got=%b%h exp=0", flags_restore, flags_out); end
    checks++; if (start_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", start_ready); end
  endtask

  task automatic test_muli();
    issue(2'd0, 4'd1, 4'd2, 4'd0, 16'd3, 32'd50, 32'd0, 4'b1010);
    checks++; if ({inject_valid, start_ready} !== 2'b10) begin failures++; $display("[TB] FAIL muli_first_valid got=%b exp=10", {inject_valid, start_ready}); end
    capture(20);
    exp = '{e_mov(4'd1), e_r(B_ADD, 4'd1, 4'd1, 4'd2), e_r(B_ADD, 4'd1, 4'd1, 4'd2), e_r(B_ADD, 4'd1, 4'd1, 4'd2)};
    checks++; if (got.size() != exp.size()) begin failures++; $display("[TB] FAIL muli_len got=%0d exp=%0d", got.size(), exp.size()); end
    foreach (exp[i]) begin
      logic [31:0] g;
      g = (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
      checks++; if (g !== exp[i]) begin failures++; $display("[TB] FAIL muli_instr%0d got=%h exp=%h", i, g, exp[i]); end
    end
    checks++; if ({done_seen, restore_seen, flags_seen} !== 6'b11_1010) begin failures++; $display("[TB] FAIL muli_done_flags got=%b exp=111010", {done_seen, restore_seen, flags_seen}); end
    checks++; if (busy_cycles != 5) begin failures++; $display("[TB] FAIL muli_busy_cycles got=%0d exp=5", busy_cycles); end
    checks++; if ({done, busy} !== 2'b00) begin failures++; $display("[TB] FAIL muli_done_pulse got=%b exp=00", {done, busy}); end
  endtask

  task automatic test_mulsi_neg();
    issue(2'd2, 4'd1, 4'd2, 4'd0, 16'hFFFE, 32'd7, 32'd0, 4'b0101);
    capture(20);
    exp = '{e_mov(4'd1), e_r(B_ADDS, 4'd1, 4'd1, 4'd2), e_r(B_ADDS, 4'd1, 4'd1, 4'd2), e_subi1(4'd1), e_not(4'd1)};
    checks++; if (got.size() != exp.size()) begin failures++; $display("[TB] FAIL mulsi_len got=%0d exp=%0d", got.size(), exp.size()); end
    foreach (exp[i]) begin
      logic [31:0] g;
      g = (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
      checks++; if (g !== exp[i]) begin failures++; $display("[TB] FAIL mulsi_instr%0d got=%h exp=%h", i, g, exp[i]); end
    end
    checks++; if ({done_seen, restore_seen, flags_seen} !== 6'b10_0000) begin failures++; $display("[TB] FAIL mulsi_no_restore got=%b exp=100000", {done_seen, restore_seen, flags_seen}); end
  endtask

  task automatic test_register_forms();
    // Alias: Rd == Rn and Rm is the smaller operand, so R3 is copied to R15 first.
    issue(2'd1, 4'd3, 4'd3, 4'd4, 16'd0, 32'd100, 32'd2, 4'b0110);
    capture(20);
    exp = '{e_mov(4'd15), e_r(B_ADD, 4'd15, 4'd15, 4'd3), e_mov(4'd3),
            e_r(B_ADD, 4'd3, 4'd3, 4'd15), e_r(B_ADD, 4'd3, 4'd3, 4'd15)};
    checks++; if (got.size() != exp.size()) begin failures++; $display("[TB] FAIL alias_len got=%0d exp=%0d", got.size(), exp.size()); end
    foreach (exp[i]) begin
      logic [31:0] g;
      g = (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
      checks++; if (g !== exp[i]) begin failures++; $display("[TB] FAIL alias_instr%0d got=%h exp=%h", i, g, exp[i]); end
    end
    checks++; if ({done_seen, restore_seen, flags_seen} !== 6'b11_0110) begin failures++; $display("[TB] FAIL alias_flags got=%b exp=110110", {done_seen, restore_seen, flags_seen}); end

    // Rn = -3 has the smaller magnitude: three adds of R7, then negate.
    issue(2'd1, 4'd5, 4'd6, 4'd7, 16'd0, 32'hFFFF_FFFD, 32'd10, 4'b0011);
    capture(20);
    exp = '{e_mov(4'd5), e_r(B_ADD, 4'd5, 4'd5, 4'd7), e_r(B_ADD, 4'd5, 4'd5, 4'd7),
            e_r(B_ADD, 4'd5, 4'd5, 4'd7), e_subi1(4'd5), e_not(4'd5)};
    checks++; if (got.size() != exp.size()) begin failures++; $display("[TB] FAIL minrn_len got=%0d exp=%0d", got.size(), exp.size()); end
    foreach (exp[i]) begin
      logic [31:0] g;
      g = (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
      checks++; if (g !== exp[i]) begin failures++; $display("[TB] FAIL minrn_instr%0d got=%h exp=%h", i, g, exp[i]); end
    end

    // Tie: multiplier is Rm, addend Rn (R6), so Rd == Rm is not an alias.
    issue(2'd1, 4'd2, 4'd6, 4'd2, 16'd0, 32'd2, 32'd2, 4'b0000);
    capture(20);
    exp = '{e_mov(4'd2), e_r(B_ADD, 4'd2, 4'd2, 4'd6), e_r(B_ADD, 4'd2, 4'd2, 4'd6)};
    checks++; if (got.size() != exp.size()) begin failures++; $display("[TB] FAIL tie_len got=%0d exp=%0d", got.size(), exp.size()); end
    foreach (exp[i]) begin
      logic [31:0] g;
      g = (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
      checks++; if (g !== exp[i]) begin failures++; $display("[TB] FAIL tie_instr%0d got=%h exp=%h", i, g, exp[i]); end
    end
  endtask

  task automatic test_zero_and_min();
    // Zero multiplier with Rd == Rn: no alias copy, a single clear.
    issue(2'd0, 4'd2, 4'd2, 4'd0, 16'd0, 32'd9, 32'd0, 4'b1111);
    capture(10);
    checks++; if (got.size() != 1) begin failures++; $display("[TB] FAIL zero_len got=%0d exp=1", got.size()); end
    checks++; if (got.size() == 0 || got[0] !== e_mov(4'd2)) begin failures++; $display("[TB] FAIL zero_instr got=%h exp=%h", (got.size() != 0) ? got[0] : 32'hx, e_mov(4'd2)); end
    checks++; if ({done_seen, restore_seen, flags_seen} !== 6'b11_1111) begin failures++; $display("[TB] FAIL zero_done got=%b exp=111111", {done_seen, restore_seen, flags_seen}); end

    // Most negative operand gives a 2^31 loop; confirm it keeps adding, then abort.
    issue(2'd3, 4'd4, 4'd5, 4'd6, 16'd0, 32'h8000_0000, 32'h8000_0000, 4'b0000);
    capture(40);
    checks++; if ({timed_out, got.size() == 40} !== 2'b11) begin failures++; $display("[TB] FAIL minneg_running got=%b exp=11", {timed_out, got.size() == 40}); end
    checks++; if (got.size() < 40 || got[39] !== e_r(B_ADDS, 4'd4, 4'd4, 4'd5)) begin failures++; $display("[TB] FAIL minneg_add got=%h exp=%h", (got.size() >= 40) ? got[39] : 32'hx, e_r(B_ADDS, 4'd4, 4'd4, 4'd5)); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if ({busy, done, inject_valid} !== 3'b000) begin failures++; $display("[TB] FAIL minneg_flush got=%b exp=000", {busy, done, inject_valid}); end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    issue(2'd0, 4'd7, 4'd8, 4'd0, 16'd4, 32'd1, 32'd0, 4'b0001);
    @(posedge clk); #1;
    @(posedge clk); #1;
    inject_ready = 1'b0;
    held = inject_instr;
    checks++; if (held !== e_r(B_ADD, 4'd7, 4'd7, 4'd8)) begin failures++; $display("[TB] FAIL stall_held got=%h exp=%h", held, e_r(B_ADD, 4'd7, 4'd7, 4'd8)); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if ({inject_valid, inject_instr} !== {1'b1, e_r(B_ADD, 4'd7, 4'd7, 4'd8)}) begin failures++; $display("[TB] FAIL stall_cycle%0d got=%b/%h exp=1/%h", i, inject_valid, inject_instr, e_r(B_ADD, 4'd7, 4'd7, 4'd8)); end
    end
    inject_ready = 1'b1;
    capture(20);
    checks++; if ({done_seen, got.size() == 3} !== 2'b11) begin failures++; $display("[TB] FAIL stall_remaining_adds got=%0d done=%b exp=3 done=1", got.size(), done_seen); end
  endtask

  task automatic test_flush_restart();
    issue(2'd0, 4'd1, 4'd2, 4'd0, 16'd7, 32'd1, 32'd0, 4'b1000);
    repeat (3) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if ({busy, done, flags_restore, start_ready} !== 4'b0001) begin failures++; $display("[TB] FAIL flush_idle got=%b exp=0001", {busy, done, flags_restore, start_ready}); end
    issue(2'd0, 4'd9, 4'd10, 4'd0, 16'd1, 32'd1, 32'd0, 4'b0100);
    checks++; if (inject_instr !== e_mov(4'd9)) begin failures++; $display("[TB] FAIL flush_restart got=%h exp=%h", inject_instr, e_mov(4'd9)); end
    capture(10);
    checks++; if ({got.size() == 2, done_seen, flags_seen} !== 6'b11_0100) begin failures++; $display("[TB] FAIL flush_restart_seq got=%b exp=110100", {got.size() == 2, done_seen, flags_seen}); end
    checks++; if (got.size() < 2 || got[1] !== e_r(B_ADD, 4'd9, 4'd9, 4'd10)) begin failures++; $display("[TB] FAIL flush_restart_add got=%h exp=%h", (got.size() >= 2) ? got[1] : 32'hx, e_r(B_ADD, 4'd9, 4'd9, 4'd10)); end
  endtask

  task automatic test_reset_mid();
    issue(2'd0, 4'd1, 4'd2, 4'd0, 16'd9, 32'd1, 32'd0, 4'b0000);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({busy, inject_valid, inject_instr} !== {2'b00, B_NOP}) begin failures++; $display("[TB] FAIL reset_mid got=%b%b/%h exp=00/%h", busy, inject_valid, inject_instr, B_NOP); end
  endtask

  initial begin
    test_reset();
    test_muli();
    test_mulsi_neg();
    test_register_forms();
    test_zero_and_min();
    test_stall();
    test_flush_restart();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ucode_mul_seq.md
# ucode_mul_seq

Parametrised microcode multiply sequencer, successor to the single-width MUL expander. It sits between the decoder and the pipeline instruction mux. It captures a MUL/MULS instruction in immediate or register form and injects a MOV / ADD(S) / SUBI / NOT sequence with the result in `Rd`, then hands control back. New in this generation:
- generic data width
- valid/ready stall handshake
- flush abort
- source/destination alias protection through a scratch register
- smaller-magnitude operand selection for register forms

## Interface
- `DATA_W`, 32: register data width; also the repeat-counter width.
- `IMM_W`, 16: immediate width; sign-extended to `DATA_W`.
- `SCRATCH_REG`, 4'd15: architectural register reserved for alias copies.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_mul` in 1: decoded MUL present; accepted only when `start_ready`=1.
- `start_ready` out 1: high in IDLE only.
- `mul_type` in 2: 0 MULI, 1 MULR, 2 MULSI, 3 MULSR.
- `dest_reg`, `src_reg`, `src2_reg` in 4 each: `Rd`, `Rn`, `Rm`.
- `immediate` in `IMM_W`: multiplier for MULI/MULSI.
- `rn_data`, `rm_data` in `DATA_W`: register values of `Rn`/`Rm`, valid with `start_mul`.
- `flags_in` in 4: NZCV at accept.
- `inject_instr` out 32: generated instruction.
- `inject_valid` out 1: `inject_instr` valid; doubles as pipeline mux select.
- `inject_ready` in 1: pipeline accepts the instruction this cycle.
- `flush` in 1: abort the sequence.
- `busy` out 1: not IDLE.
- `done` out 1: one-cycle completion pulse.
- `flags_restore` out 1, `flags_out` out 4: restore saved NZCV (non-S types).

## Operation
- Instruction encodings:
  - R-type `{op7, rd, rn, rm, 13'b0}`.
  - MOV `{op7, rd, 5'b0, imm16}`.
  - SUBI `{op7, rd, rn, 1'b0, imm16}`.
  - NOT `{op7, rd, rn, 17'b0}`.
  - NOP `{5'b11001, 27'b0}`.
- Accept (IDLE, `start_mul`): latch `Rd`, type, flags.
  - Immediate forms: multiplier M = sext(`immediate`); addend register A = `Rn`.
  - Register forms: M is the operand of smaller unsigned magnitude of |`rn_data`| and |`rm_data`|; A is the other register. On a tie, M = `rm_data`.
- Derived values:
  - count = |M| as unsigned `DATA_W`; −2^(DATA_W−1) gives count 2^(DATA_W−1).
  - neg = M[msb].
  - alias = (A == `Rd`) and count ≠ 0.
- States and transitions:
  - IDLE: go to ALIAS_CLR if alias, else CLR.
  - ALIAS_CLR: MOV `SCRATCH_REG`,#0; go to ALIAS_CP.
  - ALIAS_CP: ADD `SCRATCH_REG`,`SCRATCH_REG`,A; then A := `SCRATCH_REG`; go to CLR.
  - CLR: MOV `Rd`,#0. Go to DONE if count=0, else ADD.
  - ADD: ADD (ADDS for S types) `Rd`,`Rd`,A; count−1. On the last add, go to FIX1 if neg, else DONE.
  - FIX1: SUBI `Rd`,`Rd`,#1; go to FIX2.
  - FIX2: NOT `Rd`,`Rd`; go to DONE.
  - DONE: `done`=1; `flags_restore`=1 for MULI/MULR with `flags_out` = saved flags; go to IDLE.
- A state advances only on `inject_valid && inject_ready`. When `inject_ready`=0, hold `inject_instr` and all state unchanged.
- S types: final flags are those produced by the pipeline from the emitted instructions; no restore.
- `flush` (any state other than IDLE): next state IDLE, no `done`, no restore. `flush` has priority over `inject_ready` and `start_mul`.
- Multiplication is modulo 2^`DATA_W`.

## Timing
- Reset values:
  - state IDLE, count 0.
  - `inject_valid`=0, `inject_instr`=NOP.
  - `busy`=0, `done`=0, `flags_restore`=0, `flags_out`=0.
  - `start_ready`=1.
- Accept cycle T: first instruction is valid at T+1. All outputs are registered-state decodes with no combinational path from `start_mul`.
- With `inject_ready` held high, instruction count = 2·alias + 1 + count + 2·neg, one per cycle. `done` follows the cycle after the last accepted instruction.
- `start_mul` during `busy` is ignored; the decoder must stall.
- `rst` mid-sequence: IDLE on the next edge. The pipeline discards partial results.

## Structure
- Package `ucode_pkg`:
  - `mul_type_e`.
  - state enum.
  - opcode constants: MOV 0000000, ADD 0110001, ADDS 0111001, SUBI 0010010, NOT 0110110, NOP prefix 11001.
  - encode functions.
- One sub-module, `ucode_operand_sel`: combinational magnitude/sign/min selection producing count, neg and A.

## Test plan
- MULI R1,R2,#3 with `inject_ready`=1 → MOV R1,#0; 3× ADD R1,R1,R2; `done`; saved flags restored; 5 busy cycles.
- MULSI R1,R2,#−2 (0xFFFE) → MOV; 2× ADDS; SUBI #1; NOT; no `flags_restore`.
- MULR R3,R3,R4 with `rn_data`=100, `rm_data`=2 → M=2, A=R3 (alias) → MOV R15,#0; ADD R15,R15,R3; MOV R3,#0; 2× ADD R3,R3,R15.
- MULI #0 → single MOV Rd,#0 then `done`. MULR with `rm_data`=0x80000000 → count=2^31, neg=1.
- `inject_ready` low for 4 cycles mid-ADD → instruction held stable; total ADD count unchanged.
- `flush` during ADD (count 5 remaining) → IDLE next cycle, no `done`. New start accepted the following cycle.
